inv_mix_columns_seq: RTL and testbench

- Sequential AES-256 decryption stage: applies InvMixColumns to a full 128-bit state, one 32-bit column per clock.
- Uses a single shared column datapath (GF(2^8) multiplies by 0x09/0x0b/0x0d/0x0e, built from xtime, no lookup tables).
- Sits in the decryption round loop between AddRoundKey and InvShiftRows/InvSubBytes.
- A per-block bypass skips the transform for the round that has no InvMixColumns.

---
 rtl/inv_mix_columns_seq_if.sv | 21 ++
 rtl/inv_mix_columns_seq.sv | 125 ++++++++++++
 tb/tb_inv_mix_columns_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/inv_mix_columns_seq_if.sv
// rtl/inv_mix_columns_seq_if.sv - handshake bundle for the InvMixColumns stage
interface inv_mix_columns_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic         bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;

    modport master (
        output in_valid, data_in, bypass, out_ready,
        input  in_ready, out_valid, data_out, busy
    );

    modport slave (
        input  in_valid, data_in, bypass, out_ready,
        output in_ready, out_valid, data_out, busy
    );
endinterface

// File: rtl/inv_mix_columns_seq.sv
// rtl/inv_mix_columns_seq.sv - column-serial AES InvMixColumns with per-block bypass
module inv_mix_columns_seq #(
    parameter int NCOL = 4
) (
    input logic                  clk,
    input logic                  rst,
    inv_mix_columns_seq_if.slave bus
);
    localparam logic [1:0] LAST_COL = 2'(NCOL - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [1:0]   col_cnt_q, col_cnt_d;
    logic [127:0] work_q, work_d;
    logic [127:0] dout_q, dout_d;
    logic [31:0]  col_in;
    logic [31:0]  col_res;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // 9/b/d/e multiples are sums of the x2/x4/x8 ladder of each byte
    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2[i] = xt(a[i]);
            x4[i] = xt(x2[i]);
            x8[i] = xt(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    always_comb begin
        col_in = work_q[127:96];
        case (col_cnt_q)
            2'd0:    col_in = work_q[127:96];
            2'd1:    col_in = work_q[95:64];
            2'd2:    col_in = work_q[63:32];
            default: col_in = work_q[31:0];
        endcase
    end

    assign col_res = inv_col(col_in);

    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        work_d    = work_q;
        dout_d    = dout_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    work_d = bus.data_in;
                    if (bus.bypass) begin
                        state_d = S_DONE;
                        dout_d  = bus.data_in;
                    end else begin
                        state_d   = S_BUSY;
                        col_cnt_d = 2'd0;
                    end
                end
            end
            S_BUSY: begin
                case (col_cnt_q)
                    2'd0:    work_d[127:96] = col_res;
                    2'd1:    work_d[95:64]  = col_res;
                    2'd2:    work_d[63:32]  = col_res;
                    default: work_d[31:0]   = col_res;
                endcase
                col_cnt_d = col_cnt_q + 2'd1;
                // last column bypasses the working register straight into the output
                if (col_cnt_q == LAST_COL) begin
                    state_d = S_DONE;
                    dout_d  = {work_q[127:32], col_res};
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            col_cnt_q <= 2'd0;
            work_q    <= '0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            work_q    <= work_d;
            dout_q    <= dout_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q == S_BUSY);
    assign bus.data_out  = dout_q;
endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb/tb_inv_mix_columns_seq.sv - self-checking bench for inv_mix_columns_seq
module tb_inv_mix_columns_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    inv_mix_columns_seq_if bus ();

    inv_mix_columns_seq #(.NCOL(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] V1 = 128'h4d7ebdf8_d5d5d7d6_9fdc589d_8e4da1bc;
    localparam logic [127:0] E1 = 128'h2d26314c_d4d4d4d5_f20a225c_db135345;
    localparam logic [127:0] V2 = 128'h01010101_c6c6c6c6_00000000_ffffffff;
    localparam logic [127:0] V3 = 128'h00112233_44556677_8899aabb_ccddeeff;

    typedef struct {
        logic [127:0] din;
        logic         byp;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl [$];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // circulant matrix: row i uses base[(j - i) mod 4] for input byte j
    function automatic logic [127:0] ref_imc(input logic [127:0] s);
        logic [7:0]   base [4];
        logic [127:0] r;
        logic [7:0]   acc;
        base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(base[(j - i + 4) % 4], s[127-32*c-8*j -: 8]);
                r[127-32*c-8*i -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_block(input logic [127:0] d, input logic b, input logic [127:0] exp,
                            input string nm);
        int   k;
        logic seen_busy;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.data_in   = d;
        bus.bypass    = b;
        bus.out_ready = 1'b1;
        chk({nm, " in_ready before accept"}, 128'(bus.in_ready), 128'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.data_in  = {$urandom, $urandom, $urandom, $urandom};
        bus.bypass   = 1'($urandom);
        k = 0;
        seen_busy = 1'b0;
        while (!bus.out_valid && k < 20) begin
            seen_busy = seen_busy | bus.busy;
            @(negedge clk);
            k++;
        end
        chk({nm, " latency"}, 128'(k), b ? 128'd0 : 128'd4);
        chk({nm, " data_out"}, bus.data_out, exp);
        chk({nm, " busy seen"}, 128'(seen_busy), 128'(!b));
        @(negedge clk);
        chk({nm, " out_valid one cycle"}, 128'(bus.out_valid), 128'd0);
        chk({nm, " in_ready after"}, 128'(bus.in_ready), 128'd1);
    endtask

    initial begin
        int           k;
        int           ovn [$];
        logic [127:0] ovd [$];
        logic [127:0] rd;
        logic         rb;
        logic [127:0] e6;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.bypass    = 1'b0;
        bus.out_ready = 1'b0;

        tbl.push_back('{din: V1, byp: 1'b0, exp: E1});
        tbl.push_back('{din: V2, byp: 1'b0, exp: V2});
        tbl.push_back('{din: V3, byp: 1'b1, exp: V3});
        tbl.push_back('{din: 128'h0, byp: 1'b0, exp: 128'h0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", 128'(bus.in_ready), 128'd1);
        chk("reset out_valid", 128'(bus.out_valid), 128'd0);
        chk("reset busy", 128'(bus.busy), 128'd0);
        chk("reset data_out", bus.data_out, 128'd0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            do_block(tbl[i].din, tbl[i].byp, tbl[i].exp, $sformatf("table%0d", i));

        for (int i = 0; i < 12; i++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            rb = ($urandom_range(0, 3) == 0);
            do_block(rd, rb, rb ? rd : ref_imc(rd), $sformatf("rand%0d", i));
        end

        // backpressure with a competing state offered during the stall
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.data_in   = V1;
        bus.bypass    = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.data_in = V3;
        k = 0;
        while (!bus.out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("stall latency", 128'(k), 128'd4);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d out_valid", i), 128'(bus.out_valid), 128'd1);
            chk($sformatf("stall%0d data_out", i), bus.data_out, E1);
            chk($sformatf("stall%0d in_ready", i), 128'(bus.in_ready), 128'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        chk("stall release out_valid", 128'(bus.out_valid), 128'd0);
        chk("stall release in_ready", 128'(bus.in_ready), 128'd1);
        chk("stall release busy", 128'(bus.busy), 128'd0);

        // reset after two BUSY edges
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.data_in  = V1;
        bus.bypass   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst in_ready", 128'(bus.in_ready), 128'd1);
        chk("midrst out_valid", 128'(bus.out_valid), 128'd0);
        chk("midrst busy", 128'(bus.busy), 128'd0);
        chk("midrst data_out", bus.data_out, 128'd0);
        do_block(V1, 1'b0, E1, "after_rst");

        // back-to-back with in_valid and out_ready held high
        e6 = ref_imc(V3);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.data_in   = V1;
        bus.bypass    = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ovn.push_back(n);
                ovd.push_back(bus.data_out);
            end
            if (n == 0) bus.data_in = V3;
            if (n == 6) bus.in_valid = 1'b0;
        end
        chk("b2b output count", 128'(ovn.size()), 128'd2);
        if (ovn.size() >= 2) begin
            chk("b2b first data", ovd[0], E1);
            chk("b2b second data", ovd[1], e6);
            chk("b2b spacing", 128'(ovn[1] - ovn[0]), 128'd6);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
